parity_serial_arbiter: RTL and testbench

PARITY_SERIAL_ARBITER -- requirements
Module: parity_serial_arbiter

---
 rtl/parity_serial_arbiter.sv | 135 +++++++++++++
 tb/tb_parity_serial_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_serial_arbiter.sv
// Two-requester round-robin arbiter that serialises the granted word LSB first with running parity.
// Build option: define PARITY_ODD_EN for odd parity (initial parity state 1); default is even parity.
module parity_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             parity_out,
    output logic             done,
    output logic             done_id,
    output logic             done_parity,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PARITY_ODD_EN
    localparam logic PAR_INIT = 1'b1;
`else
    localparam logic PAR_INIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             par_q, par_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             bit_valid_q, bit_valid_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             done_par_q, done_par_d;

    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] data_sel;

    // With both requesters valid, the one not granted last wins.
    always_comb begin
        grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        accept   = (state_q == IDLE) && (req0_valid || req1_valid) && !reset;
        data_sel = grant_id ? req1_data : req0_data;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        par_d   = par_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = data_sel;
                    id_d    = grant_id;
                    cnt_d   = '0;
                    par_d   = PAR_INIT;
                    last_d  = grant_id;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The word shifts right so the current bit is always word_q[0].
                word_d = word_q >> 1;
                par_d  = par_q ^ word_q[0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE);
        bit_valid_d = (state_d == SHIFT);
        done_d      = (state_d == DONE);
        done_id_d   = done_d & id_d;
        done_par_d  = done_d & par_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            par_q       <= 1'b0;
            last_q      <= 1'b1;
            busy_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            done_par_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            par_q       <= par_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            done_par_q  <= done_par_d;
        end
    end

    assign busy        = busy_q;
    assign bit_valid   = bit_valid_q;
    assign bit_out     = bit_valid_q & word_q[0];
    assign parity_out  = bit_valid_q & (par_q ^ word_q[0]);
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign done_parity = done_par_q;

endmodule

// File: tb/tb_parity_serial_arbiter.sv
// Directed self-checking bench for parity_serial_arbiter (WIDTH=8), even or odd parity build.
module tb_parity_serial_arbiter;
    localparam int WIDTH = 8;
`ifdef PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             req1_ready;
    logic             bit_out, bit_valid, parity_out, done, done_id, done_parity, busy;

    int   checks = 0;
    int   errors = 0;
    logic both_seen = 1'b0;

    parity_serial_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .parity_out(parity_out),
        .done(done), .done_id(done_id), .done_parity(done_parity), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (req0_ready && req1_ready) both_seen <= 1'b1;

    // Returns the granted requester (-1 on timeout); samples 1ns after each falling edge.
    task automatic wait_any(output int g);
        g = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin g = 0; break; end
            if (req1_ready) begin g = 1; break; end
            @(negedge clk);
        end
    endtask

    // Cycle 0 is the accept cycle; records bits, parity_out and the cycle index of done.
    task automatic collect(output logic [7:0] bits, output logic [7:0] pouts, output int nbits,
                           output int lat, output logic did, output logic dpar);
        bits = '0; pouts = '0; nbits = 0; lat = -1; did = 1'bx; dpar = 1'bx;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk); #1;
            if (bit_valid && nbits < 8) begin
                bits[nbits]  = bit_out;
                pouts[nbits] = parity_out;
                nbits++;
            end
            if (done) begin
                lat = c; did = done_id; dpar = done_parity;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({req0_ready, req1_ready, busy, done, bit_valid} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got r0=%b r1=%b busy=%b done=%b bv=%b, want all 0",
                         req0_ready, req1_ready, busy, done, bit_valid);
            end
        end
        reset = 1'b0; #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single_word();
        logic [7:0] bits, pouts, exp_p;
        int nbits, lat, g;
        logic did, dpar, run;
        @(negedge clk);
        req0_data = 8'hA5; req0_valid = 1'b1;
        wait_any(g);
        checks++;
        if (g !== 0) begin errors++; $display("FAIL single0_grant: got %0d, want 0", g); end
        @(posedge clk); #1; req0_valid = 1'b0;
        collect(bits, pouts, nbits, lat, did, dpar);
        run = ODD;
        for (int i = 0; i < 8; i++) begin
            run = run ^ req0_data[i];
            exp_p[i] = run;
        end
        checks++;
        if (bits !== 8'hA5 || nbits != 8) begin
            errors++; $display("FAIL single0_bits: got %h (%0d bits), want a5 (8 bits)", bits, nbits);
        end
        checks++;
        if (pouts !== exp_p) begin
            errors++; $display("FAIL single0_parity_out: got %b, want %b", pouts, exp_p);
        end
        checks++;
        if (lat != 9) begin errors++; $display("FAIL single0_latency: got %0d, want 9", lat); end
        checks++;
        if (did !== 1'b0 || dpar !== ODD) begin
            errors++; $display("FAIL single0_done: got id=%b par=%b, want id=0 par=%b", did, dpar, ODD);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single0_after_done: got done=%b busy=%b, want 0 0", done, busy);
        end
        req1_data = 8'h07; req1_valid = 1'b1;
        wait_any(g);
        checks++;
        if (g !== 1) begin errors++; $display("FAIL single1_grant: got %0d, want 1", g); end
        @(posedge clk); #1; req1_valid = 1'b0;
        collect(bits, pouts, nbits, lat, did, dpar);
        checks++;
        if (bits !== 8'h07 || lat != 9 || did !== 1'b1 || dpar !== ~ODD) begin
            errors++;
            $display("FAIL single1_word: got bits=%h lat=%0d id=%b par=%b, want 07 9 1 %b",
                     bits, lat, did, dpar, ~ODD);
        end
    endtask

    task automatic test_contention();
        logic [7:0] bits, pouts;
        int nbits, lat, g;
        logic did, dpar;
        int   exp_g[4] = '{0, 1, 0, 1};
        logic exp_par[4];
        exp_par = '{1'b1 ^ ODD, ODD, 1'b1 ^ ODD, ODD};
        both_seen = 1'b0;
        @(negedge clk);
        req0_data = 8'h01; req1_data = 8'h03;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            wait_any(g);
            @(posedge clk);
            collect(bits, pouts, nbits, lat, did, dpar);
            checks++;
            if (g != exp_g[w] || did !== exp_g[w][0] || dpar !== exp_par[w]) begin
                errors++;
                $display("FAIL contention_word%0d: got grant=%0d id=%b par=%b, want grant=%0d par=%b",
                         w, g, did, dpar, exp_g[w], exp_par[w]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (both_seen !== 1'b0) begin
            errors++; $display("FAIL contention_both_ready: got %b, want 0", both_seen);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] bits, pouts;
        int nbits, lat, g;
        logic did, dpar, seen_done;
        @(negedge clk);
        req0_data = 8'h5A; req0_valid = 1'b1;
        wait_any(g);
        @(posedge clk); #1; req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
            errors++; $display("FAIL midword_count3: got bv=%b bit=%b, want 1 1", bit_valid, bit_out);
        end
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midword_idle: got busy=%b bv=%b done=%b, want 0 0 0", busy, bit_valid, done);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin errors++; $display("FAIL midword_no_done: got 1, want 0"); end
        req1_data = 8'hFF; req1_valid = 1'b1;
        wait_any(g);
        @(posedge clk); #1; req1_valid = 1'b0;
        collect(bits, pouts, nbits, lat, did, dpar);
        checks++;
        if (g != 1 || bits !== 8'hFF || lat != 9 || did !== 1'b1 || dpar !== ODD) begin
            errors++;
            $display("FAIL midword_next: got grant=%0d bits=%h lat=%0d id=%b par=%b, want 1 ff 9 1 %b",
                     g, bits, lat, did, dpar, ODD);
        end
    endtask

    task automatic test_parity_config();
        logic [7:0] bits, pouts;
        int nbits, lat, g;
        logic did, dpar;
        logic [7:0] vec[2] = '{8'hA5, 8'h00};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req0_data = vec[k]; req0_valid = 1'b1;
            wait_any(g);
            @(posedge clk); #1; req0_valid = 1'b0;
            collect(bits, pouts, nbits, lat, did, dpar);
            checks++;
            if (bits !== vec[k] || dpar !== ODD) begin
                errors++;
                $display("FAIL config_word%0d: got bits=%h par=%b, want %h %b", k, bits, dpar, vec[k], ODD);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_contention();
        test_reset_mid_word();
        test_parity_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
